// File: rtl/cb_rr_fifo_if.sv
// Handshake bundle for cb_rr_fifo: source write ports, sink dispatch ports,
// flush and occupancy. The buffer attaches through the slave modport.
interface cb_rr_fifo_if #(
  parameter int IN     = 2,
  parameter int OUT    = 1,
  parameter int DWIDTH = 32,
  parameter int BWIDTH = 3
);
  logic                         flush;
  logic [IN-1:0]                src_req;
  logic [IN-1:0][DWIDTH-1:0]    src_data;
  logic [IN-1:0]                src_gnt;
  logic [OUT-1:0]               snk_req;
  logic [OUT-1:0]               snk_vld;
  logic [DWIDTH-1:0]            snk_data;
  logic [BWIDTH:0]              count;

  modport master (
    output flush, src_req, src_data, snk_req,
    input  src_gnt, snk_vld, snk_data, count
  );

  modport slave (
    input  flush, src_req, src_data, snk_req,
    output src_gnt, snk_vld, snk_data, count
  );
endinterface

// File: rtl/cb_rr_fifo.sv
// Round-robin many-to-many channel buffer: IN sources share one FIFO that
// dispatches round-robin to OUT sinks. Define CB_RR_FIFO_HWM_EN to add hwm.
module cb_rr_fifo #(
  parameter int IN     = 2,
  parameter int OUT    = 1,
  parameter int DWIDTH = 32,
  parameter int BWIDTH = 3
) (
  input  logic            clk,
  input  logic            rstn,
`ifdef CB_RR_FIFO_HWM_EN
  output logic [BWIDTH:0] hwm,
`endif
  cb_rr_fifo_if.slave     bus
);
  localparam int DEPTH = 1 << BWIDTH;
  localparam int IW    = (IN > 1) ? $clog2(IN) : 1;
  localparam int OW    = (OUT > 1) ? $clog2(OUT) : 1;
  localparam logic [BWIDTH:0] FULL_COUNT = (BWIDTH + 1)'(DEPTH);

  logic [DWIDTH-1:0] buff [DEPTH];

  logic [BWIDTH-1:0] wr_ptr_reg;
  logic [BWIDTH-1:0] rd_ptr_reg;
  logic [BWIDTH:0]   count_reg;
  logic [IW-1:0]     wr_rr_reg;
  logic [OW-1:0]     rd_rr_reg;
  logic [IN-1:0]     src_gnt_reg;
  logic [OUT-1:0]    snk_vld_reg;
  logic [DWIDTH-1:0] snk_data_reg;

  logic [IN-1:0]     wr_elig;
  logic [IN-1:0]     wr_elig_hi;
  logic [IN-1:0]     wr_onehot;
  logic [IW-1:0]     wr_sel;
  logic [IW-1:0]     wr_rr_next;
  logic [OUT-1:0]    rd_elig_hi;
  logic [OUT-1:0]    rd_onehot;
  logic [OW-1:0]     rd_sel;
  logic [OW-1:0]     rd_rr_next;
  logic              push;
  logic              pop;

  // A source granted last cycle is masked so it can present fresh data.
  for (genvar gi = 0; gi < IN; gi++) begin : g_wr
    assign wr_elig[gi]    = bus.src_req[gi] & ~src_gnt_reg[gi];
    assign wr_elig_hi[gi] = wr_elig[gi] & (IW'(gi) >= wr_rr_reg);
    assign wr_onehot[gi]  = (wr_sel == IW'(gi));
  end

  for (genvar gi = 0; gi < OUT; gi++) begin : g_rd
    assign rd_elig_hi[gi] = bus.snk_req[gi] & (OW'(gi) >= rd_rr_reg);
    assign rd_onehot[gi]  = (rd_sel == OW'(gi));
  end

  // Lowest requester at or above the RR pointer, else wrap to the lowest overall.
  always_comb begin
    wr_sel = '0;
    for (int k = IN - 1; k >= 0; k--) begin
      if ((|wr_elig_hi) ? wr_elig_hi[k] : wr_elig[k]) begin
        wr_sel = IW'(k);
      end
    end
  end

  always_comb begin
    rd_sel = '0;
    for (int k = OUT - 1; k >= 0; k--) begin
      if ((|rd_elig_hi) ? rd_elig_hi[k] : bus.snk_req[k]) begin
        rd_sel = OW'(k);
      end
    end
  end

  assign wr_rr_next = (wr_sel == IW'(IN - 1)) ? '0 : wr_sel + 1'b1;
  assign rd_rr_next = (rd_sel == OW'(OUT - 1)) ? '0 : rd_sel + 1'b1;

  // Full/empty come from the registered count only: no pass-through.
  assign push = (|wr_elig) & (count_reg < FULL_COUNT) & ~bus.flush;
  assign pop  = (|bus.snk_req) & (count_reg != '0) & ~bus.flush;

  always_ff @(posedge clk) begin
    if (push) begin
      buff[wr_ptr_reg] <= bus.src_data[wr_sel];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      wr_rr_reg    <= '0;
      rd_rr_reg    <= '0;
      src_gnt_reg  <= '0;
      snk_vld_reg  <= '0;
      snk_data_reg <= '0;
    end else if (bus.flush) begin
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      count_reg   <= '0;
      src_gnt_reg <= '0;
      snk_vld_reg <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
        wr_rr_reg  <= wr_rr_next;
      end
      if (pop) begin
        rd_ptr_reg   <= rd_ptr_reg + 1'b1;
        rd_rr_reg    <= rd_rr_next;
        snk_data_reg <= buff[rd_ptr_reg];
      end
      src_gnt_reg <= push ? wr_onehot : '0;
      snk_vld_reg <= pop ? rd_onehot : '0;
      unique case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

`ifdef CB_RR_FIFO_HWM_EN
  logic [BWIDTH:0] hwm_reg;

  // Tracks the registered count, so the peak shows up one cycle later.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hwm_reg <= '0;
    end else if (bus.flush) begin
      hwm_reg <= '0;
    end else if (count_reg > hwm_reg) begin
      hwm_reg <= count_reg;
    end
  end

  assign hwm = hwm_reg;
`endif

  assign bus.src_gnt  = src_gnt_reg;
  assign bus.snk_vld  = snk_vld_reg;
  assign bus.snk_data = snk_data_reg;
  assign bus.count    = count_reg;
endmodule
